// File: rtl/risc_v_mike_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : risc_v_mike_fetch_unit (+ risc_v_mike_pkg)
//  Brief    : PC generator and small fetch queue feeding decode; optional
//             misaligned-redirect check under RISC_V_MIKE_FETCH_ALIGN_CHK_EN.
//  Revision : 1.0 - initial release
// ============================================================================

package risc_v_mike_pkg;
  typedef logic [31:0] t_pc_addr;
  localparam t_pc_addr MEM_MAP_TEXT_LOWER_LIMIT = 32'h0040_0000;
endpackage

module risc_v_mike_fetch_unit #(
  parameter logic [31:0] RESET_PC = risc_v_mike_pkg::MEM_MAP_TEXT_LOWER_LIMIT,
  parameter int          FQ_DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          fetch_en,
  output risc_v_mike_pkg::t_pc_addr     imem_addr,
  input  logic [31:0]                   imem_rd_data,
  input  logic                          redirect_valid,
  input  logic [31:0]                   redirect_pc,
  output logic                          if_valid,
  input  logic                          if_ready,
  output logic [31:0]                   if_instr,
  output logic [31:0]                   if_pc,
  output logic [$clog2(FQ_DEPTH):0]     fq_count,
  output logic                          fetch_misalign
);

  localparam int                 C_PTR_W = $clog2(FQ_DEPTH);
  localparam int                 C_CNT_W = C_PTR_W + 1;
  localparam logic [C_CNT_W-1:0] C_DEPTH = C_CNT_W'(FQ_DEPTH);

  logic [31:0]        r_pc;
  logic [C_PTR_W-1:0] r_head;
  logic [C_PTR_W-1:0] r_tail;
  logic [C_CNT_W-1:0] r_count;
  logic [31:0]        r_fq_pc    [FQ_DEPTH];
  logic [31:0]        r_fq_instr [FQ_DEPTH];

  logic        w_pop;
  logic        w_push;
  logic [31:0] w_redirect_target;

  assign w_pop  = if_valid & if_ready;
  assign w_push = fetch_en & ~redirect_valid & ((r_count < C_DEPTH) | w_pop);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pc    <= RESET_PC;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < FQ_DEPTH; i++) begin
        r_fq_pc[i]    <= '0;
        r_fq_instr[i] <= '0;
      end
    end else if (redirect_valid) begin
      // Flush wins over any pop decode might be taking this cycle.
      r_pc    <= w_redirect_target;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_fq_pc[r_tail]    <= r_pc;
        r_fq_instr[r_tail] <= imem_rd_data;
        r_tail             <= r_tail + 1'b1;
        r_pc               <= r_pc + 32'd4;
      end
      if (w_pop) begin
        r_head <= r_head + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef RISC_V_MIKE_FETCH_ALIGN_CHK_EN
  logic r_misalign;

  assign w_redirect_target = redirect_pc;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_misalign <= 1'b0;
    end else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
      r_misalign <= 1'b1;
    end
  end

  assign fetch_misalign = r_misalign;
`else
  logic w_unused_low_bits;

  // Low target bits are dropped so the PC always stays word-aligned.
  assign w_redirect_target = {redirect_pc[31:2], 2'b00};
  assign w_unused_low_bits = ^redirect_pc[1:0];
  assign fetch_misalign    = 1'b0;
`endif

  assign imem_addr = r_pc;
  assign fq_count  = r_count;
  assign if_valid  = (r_count != '0);
  assign if_instr  = rst ? r_fq_instr[r_head] : 32'h0;
  assign if_pc     = rst ? r_fq_pc[r_head]    : 32'h0;

endmodule

`default_nettype wire

// File: tb/tb_risc_v_mike_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_risc_v_mike_fetch_unit
//  Brief    : Directed self-checking bench for the fetch unit (FQ_DEPTH=2).
//  Revision : 1.0 - initial release
// ============================================================================

module tb_risc_v_mike_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rd_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [1:0]  fq_count;
  logic        fetch_misalign;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Instruction memory: each word is the bitwise inverse of its address.
  assign imem_rd_data = ~imem_addr;

  risc_v_mike_fetch_unit #(
    .RESET_PC (32'h0040_0000),
    .FQ_DEPTH (2)
  ) u_dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_en       (fetch_en),
    .imem_addr      (imem_addr),
    .imem_rd_data   (imem_rd_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .fq_count       (fq_count),
    .fetch_misalign (fetch_misalign)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst            = 1'b0;
    fetch_en       = 1'b0;
    if_ready       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    step();
    step();

    // Reset state
    check("rst_count",    32'(fq_count), 32'd0);
    check("rst_valid",    32'(if_valid), 32'd0);
    check("rst_addr",     imem_addr, 32'h0040_0000);
    check("rst_instr",    if_instr, 32'h0);
    check("rst_pc",       if_pc, 32'h0);
    check("rst_misalign", 32'(fetch_misalign), 32'd0);

    // Streaming with decode always ready
    rst = 1'b1; fetch_en = 1'b1; if_ready = 1'b1;
    #1;
    check("s0_addr",  imem_addr, 32'h0040_0000);
    check("s0_valid", 32'(if_valid), 32'd0);
    step();
    check("s1_valid", 32'(if_valid), 32'd1);
    check("s1_pc",    if_pc, 32'h0040_0000);
    check("s1_instr", if_instr, ~32'h0040_0000);
    check("s1_addr",  imem_addr, 32'h0040_0004);
    check("s1_count", 32'(fq_count), 32'd1);
    step();
    check("s2_pc",    if_pc, 32'h0040_0004);
    check("s2_addr",  imem_addr, 32'h0040_0008);
    check("s2_count", 32'(fq_count), 32'd1);

    // Mid-operation reset, then fill with decode stalled
    rst = 1'b0;
    step();
    check("r2_count", 32'(fq_count), 32'd0);
    check("r2_addr",  imem_addr, 32'h0040_0000);
    rst = 1'b1; if_ready = 1'b0;
    step();
    check("f1_count", 32'(fq_count), 32'd1);
    step();
    check("f2_count", 32'(fq_count), 32'd2);
    check("f2_addr",  imem_addr, 32'h0040_0008);
    step();
    check("f3_count", 32'(fq_count), 32'd2);
    check("f3_addr",  imem_addr, 32'h0040_0008);
    check("f3_pc",    if_pc, 32'h0040_0000);
    if_ready = 1'b1;
    step();
    check("pp_count", 32'(fq_count), 32'd2);
    check("pp_pc",    if_pc, 32'h0040_0004);
    check("pp_addr",  imem_addr, 32'h0040_000C);

    // Redirect while full, concurrent pop discarded
    redirect_valid = 1'b1; redirect_pc = 32'h0040_0040;
    step();
    check("rd_count", 32'(fq_count), 32'd0);
    check("rd_valid", 32'(if_valid), 32'd0);
    check("rd_addr",  imem_addr, 32'h0040_0040);
    redirect_valid = 1'b0;
    step();
    check("rd1_valid", 32'(if_valid), 32'd1);
    check("rd1_pc",    if_pc, 32'h0040_0040);
    check("rd1_instr", if_instr, ~32'h0040_0040);
    check("rd1_addr",  imem_addr, 32'h0040_0044);

    // Misaligned redirect
    redirect_valid = 1'b1; redirect_pc = 32'h0040_0042;
    step();
    check("ma_count", 32'(fq_count), 32'd0);
`ifdef RISC_V_MIKE_FETCH_ALIGN_CHK_EN
    check("ma_addr",     imem_addr, 32'h0040_0042);
    check("ma_misalign", 32'(fetch_misalign), 32'd1);
`else
    check("ma_addr",     imem_addr, 32'h0040_0040);
    check("ma_misalign", 32'(fetch_misalign), 32'd0);
`endif

    // Redirect with fetch disabled still applies; PC then holds
    redirect_pc = 32'hFFFF_FFFC; fetch_en = 1'b0;
    step();
    check("wr_addr",  imem_addr, 32'hFFFF_FFFC);
    redirect_valid = 1'b0;
    step();
    check("hold_addr",  imem_addr, 32'hFFFF_FFFC);
    check("hold_count", 32'(fq_count), 32'd0);
`ifdef RISC_V_MIKE_FETCH_ALIGN_CHK_EN
    check("ma_sticky", 32'(fetch_misalign), 32'd1);
`endif
    fetch_en = 1'b1; if_ready = 1'b0;
    step();
    check("wrap_addr",  imem_addr, 32'h0000_0000);
    check("wrap_pc",    if_pc, 32'hFFFF_FFFC);
    check("wrap_instr", if_instr, 32'h0000_0003);
    check("wrap_count", 32'(fq_count), 32'd1);

    // Drain with fetch disabled
    fetch_en = 1'b0; if_ready = 1'b1;
    step();
    check("dr_count", 32'(fq_count), 32'd0);
    check("dr_addr",  imem_addr, 32'h0000_0000);

    // Fill, then reset together with a redirect
    fetch_en = 1'b1; if_ready = 1'b0;
    step();
    step();
    check("ff_count", 32'(fq_count), 32'd2);
    rst = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0040_0081;
    step();
    check("rr_count",    32'(fq_count), 32'd0);
    check("rr_valid",    32'(if_valid), 32'd0);
    check("rr_addr",     imem_addr, 32'h0040_0000);
    check("rr_misalign", 32'(fetch_misalign), 32'd0);
    check("rr_instr",    if_instr, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/risc_v_mike_fetch_unit.md
RISC_V_MIKE_FETCH_UNIT -- requirements
Module: risc_v_mike_fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default MEM_MAP_TEXT_LOWER_LIMIT (risc_v_mike_pkg), meaning the first fetch address after reset.
REQ-002 The block SHALL have parameter FQ_DEPTH, default 2, meaning fetch-queue entries; legal values are powers of two from 2 to 8.
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-005 The block SHALL have port fetch_en  input  1  when 1, fetch is allowed; when 0, PC holds and no push occurs.
REQ-006 The block SHALL have port imem_addr  output  t_pc_addr (32)  address to instruction memory; combinational copy of pc_q.
REQ-007 The block SHALL have port imem_rd_data  input  32  instruction word returned combinationally for imem_addr in the same cycle.
REQ-008 The block SHALL have port redirect_valid  input  1  branch/jump redirect request.
REQ-009 The block SHALL have port redirect_pc  input  32  redirect target.
REQ-010 The block SHALL have port if_valid  output  1  queue head holds a valid instruction for decode.
REQ-011 The block SHALL have port if_ready  input  1  decode accepts the head this cycle.
REQ-012 The block SHALL have port if_instr  output  32  head instruction word.
REQ-013 The block SHALL have port if_pc  output  32  head instruction address.
REQ-014 The block SHALL have port fq_count  output  $clog2(FQ_DEPTH)+1  current queue occupancy.
REQ-015 The block SHALL have port fetch_misalign  output  1  sticky misaligned-redirect flag (see Configuration).

Function
REQ-016 pop SHALL be defined as if_valid & if_ready; push SHALL be defined as fetch_en & !redirect_valid & (fq_count < FQ_DEPTH | pop).
REQ-017 On push, the block SHALL write {pc_q, imem_rd_data} at the tail and set pc_q <= pc_q + 4; the addition SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-018 if_valid SHALL equal (fq_count != 0), and if_instr/if_pc SHALL be driven from the head entry, with no combinational path from imem_rd_data to if_*.
REQ-019 Latency from imem_addr presented to the same entry appearing at if_* with if_valid=1 SHALL be exactly 1 cycle when the queue is empty.
REQ-020 On simultaneous push and pop, fq_count SHALL be unchanged; when full, a push SHALL occur only if a pop occurs in the same cycle.
REQ-021 When redirect_valid=1, the queue SHALL be flushed (fq_count=0 next cycle, pointers reset) and pc_q <= redirect_pc, with no push that cycle; a concurrent pop SHALL be discarded.
REQ-022 When fetch_en=0 and redirect_valid=0, pc_q SHALL hold while pops continue to drain the queue.
REQ-023 When the queue is empty, if_instr and if_pc SHALL still drive stale head data, which decode ignores because if_valid=0.
REQ-024 When redirect_valid=1 and fetch_en=0 in the same cycle, the redirect SHALL still take effect.

Reset
REQ-025 While rst=0 at a clock edge, the block SHALL set pc_q=RESET_PC, clear the pointers, set fq_count=0, if_valid=0 and fetch_misalign=0; reset SHALL override redirect_valid and push.
REQ-026 During reset, if_instr and if_pc SHALL be 32'h0.
REQ-027 Reset asserted mid-operation SHALL discard all queued entries within one cycle.

Configuration
REQ-028 With macro RISC_V_MIKE_FETCH_ALIGN_CHK_EN defined, a redirect whose redirect_pc[1:0] != 0 SHALL set fetch_misalign=1, sticky until reset, and the PC SHALL load redirect_pc unchanged.
REQ-029 Without RISC_V_MIKE_FETCH_ALIGN_CHK_EN, fetch_misalign SHALL be tied 0 and the PC SHALL load {redirect_pc[31:2], 2'b00}.

Verification
REQ-030 Bench SHALL cover: RESET_PC=32'h0040_0000, rst released, fetch_en=1, if_ready=1 -> imem_addr 0x400000, 0x400004, ...; if_valid first high 1 cycle after release with if_pc=0x400000.
REQ-031 Bench SHALL cover: if_ready=0 with FQ_DEPTH=2 -> fq_count reaches 2, imem_addr holds at 0x400008; if_ready=1 -> the next pop and push occur in the same cycle and fq_count stays 2.
REQ-032 Bench SHALL cover: redirect_valid=1 with redirect_pc=0x400040 while fq_count=2 -> next cycle fq_count=0, if_valid=0, imem_addr=0x400040; one cycle later if_pc=0x400040.
REQ-033 Bench SHALL cover: redirect_pc=0x400042 -> with the macro, fetch_misalign=1 and stays 1 until rst; without it, imem_addr=0x400040 and fetch_misalign=0.
REQ-034 Bench SHALL cover: redirect to 0xFFFF_FFFC then one push -> imem_addr=0x0000_0000.
REQ-035 Bench SHALL cover: rst=0 asserted while fq_count=2 and redirect_valid=1 -> next cycle fq_count=0, imem_addr=RESET_PC, fetch_misalign=0.
